systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameters SHALL be: N, default 8, array dimension; DATA_WIDTH, default 8, operand width; ACC_WIDTH, default 32, partial-sum width; ADDR_WIDTH, default 12, tile-buffer word address; CNT_WIDTH, default 16, vector count width.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  job request; cmd_ready  out  1  job accepted when both high.
REQ-005 cmd_w_base  in  ADDR_WIDTH  first weight-row address; cmd_x_base  in  ADDR_WIDTH  first activation address.
REQ-006 cmd_num_vec  in  CNT_WIDTH  activation vectors to stream; cmd_skip_weights  in  1  reuse latched weights.
REQ-007 mem_rd_en  out  1  tile-buffer read strobe; mem_rd_addr  out  ADDR_WIDTH  read address; mem_rd_data  in  N*DATA_WIDTH  read data, valid exactly one cycle after mem_rd_en.
REQ-008 load_weight_in  out  N  per-row weight-load tag; valid_in  out  1  beat valid; ready_out  in  1  core ready; x_in  out  N*DATA_WIDTH  beat payload; y_in  out  N*ACC_WIDTH  initial sums.
REQ-009 weight_latch_en  out  1  single-cycle weight latch pulse to core.
REQ-010 busy  out  1  job in progress; done  out  1  single-cycle job-complete pulse.

Function
REQ-011 FSM states SHALL be IDLE, W_LOAD, W_WAIT, LATCH, X_STREAM, DONE; busy = (state != IDLE); cmd_ready = (state == IDLE).
REQ-012 On acceptance in IDLE the block SHALL capture all cmd fields and go to X_STREAM if cmd_skip_weights=1, else to W_LOAD.
REQ-013 W_LOAD SHALL read N words from cmd_w_base upward and emit N beats with load_weight_in = all ones, y_in = 0; leave to W_WAIT in the cycle after the N-th beat is accepted.
REQ-014 W_WAIT SHALL count 2*N cycles, then go to LATCH; LATCH SHALL assert weight_latch_en for exactly one cycle, then go to X_STREAM (or DONE if num_vec = 0).
REQ-015 X_STREAM SHALL read num_vec words from cmd_x_base upward and emit beats with load_weight_in = 0, y_in = 0; go to DONE after the last beat is accepted; num_vec = 0 with skip_weights=1 SHALL go directly to DONE.
REQ-016 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-017 A beat is transferred when valid_in && ready_out; x_in, load_weight_in and valid_in SHALL stay stable while valid_in && !ready_out.
REQ-018 Beat payload SHALL come from a 2-entry FIFO fed by mem_rd_data; a read SHALL issue only when (FIFO occupancy + reads in flight) < 2, so no read data is dropped under backpressure.
REQ-019 With ready_out held high, the first valid_in SHALL appear in the third cycle after cmd acceptance, and beats SHALL then be back-to-back with no bubbles.
REQ-020 Read addresses SHALL increment by 1 per read and wrap modulo 2^ADDR_WIDTH.
REQ-021 Exactly N (weights) or num_vec (activations) reads SHALL be issued per phase; no speculative reads past the phase end.
REQ-022 cmd_valid outside IDLE SHALL be ignored; the FIFO SHALL be empty at every phase boundary.

Reset
REQ-023 While rst_n is low: state IDLE; FIFO and in-flight count cleared; valid_in, mem_rd_en, weight_latch_en, done, busy = 0; load_weight_in, x_in, y_in, mem_rd_addr = 0; cmd_ready = 1 after release.
REQ-024 Reset mid-job SHALL abandon the job with no further beats, reads or pulses.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding and the LATCH_DELAY = 2*N constant.
REQ-026 The 2-entry FIFO SHALL be a sub-module, feeder_skid_fifo, parameterised by width.

Verification
REQ-027 N=8, w_base=0x010, x_base=0x100, num_vec=4, ready_out=1 -> 8 weight beats from 0x010..0x017 with load_weight_in=0xFF, 16 idle cycles, one weight_latch_en, 4 beats from 0x100..0x103, done one cycle later.
REQ-028 Same job, ready_out toggling 1,0,0,1 repeating -> identical beat sequence, payload held stable during stalls, no duplicated or lost words.
REQ-029 skip_weights=1, num_vec=3 -> no load_weight beats, no weight_latch_en, 3 activation beats, then done.
REQ-030 x_base=0xFFE, num_vec=4 -> reads at 0xFFE, 0xFFF, 0x000, 0x001.
REQ-031 num_vec=0, skip_weights=0 -> weight phase and latch pulse, then done, zero activation beats; skip_weights=1 -> done with no beats.
REQ-032 rst_n pulled low during X_STREAM after 2 of 10 beats -> all outputs 0 immediately, cmd_ready=1 after release, no beats until a new command.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: FSM state encoding and
// the weight-settle delay between the last weight beat and the latch pulse.
package systolic_feeder_pkg;

    // Job sequencing states of the feeder.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_LOAD   = 3'd1,
        W_WAIT   = 3'd2,
        LATCH    = 3'd3,
        X_STREAM = 3'd4,
        DONE     = 3'd5
    } feeder_state_e;

    // Array dimension the constants below are quoted for.
    localparam int DEFAULT_N = 8;

    // Cycles spent in W_WAIT so the last weight row can ripple through
    // the core before it is latched.
    localparam int LATCH_DELAY = 2 * DEFAULT_N;

    // Same delay for an arbitrary array dimension.
    function automatic int latch_delay(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/systolic_feeder_skid_fifo.sv
// Two-entry FIFO between the tile-buffer read port and the core beat
// interface. Holds the head word stable while the core stalls.
module feeder_skid_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic             w_pop;
    logic             w_push;

    // Pops only when data is present; pushes only when a slot is free or
    // is being freed in the same cycle.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is cleared too, so the payload bus reads zero
            // straight out of reset instead of whatever the flops powered up with.
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array feeder: streams N weight rows then num_vec activation
// vectors from a tile buffer into the array core, with a latch pulse
// between the phases and full backpressure handling on the beat interface.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_w_base,
    input  logic [ADDR_WIDTH-1:0]   cmd_x_base,
    input  logic [CNT_WIDTH-1:0]    cmd_num_vec,
    input  logic                    cmd_skip_weights,

    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [N*DATA_WIDTH-1:0] mem_rd_data,

    output logic [N-1:0]            load_weight_in,
    output logic                    valid_in,
    input  logic                    ready_out,
    output logic [N*DATA_WIDTH-1:0] x_in,
    output logic [N*ACC_WIDTH-1:0]  y_in,

    output logic                    weight_latch_en,
    output logic                    busy,
    output logic                    done
);

    localparam int                   ROW_WIDTH   = N * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] N_WORDS     = CNT_WIDTH'(N);
    localparam logic [CNT_WIDTH-1:0] W_WAIT_LAST = CNT_WIDTH'(latch_delay(N) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    feeder_state_e           r_state;
    logic [ADDR_WIDTH-1:0]   r_x_base;
    logic [CNT_WIDTH-1:0]    r_num_vec;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [CNT_WIDTH-1:0]    r_rd_left;
    logic [CNT_WIDTH-1:0]    r_beat_left;
    logic [CNT_WIDTH-1:0]    r_wait_cnt;
    logic                    r_rd_inflight;
    logic                    r_weight_latch_en;
    logic                    r_done;

    logic                    w_streaming;
    logic                    w_fifo_valid;
    logic [ROW_WIDTH-1:0]    w_fifo_data;
    logic [1:0]              w_fifo_count;
    logic                    w_beat;
    logic [2:0]              w_credit_used;
    logic [2:0]              w_credit_cap;
    logic                    w_rd_en;

    assign w_streaming = (r_state == W_LOAD) || (r_state == X_STREAM);
    assign w_beat      = w_fifo_valid && ready_out;

    // A read is allowed only while every word it could produce has a FIFO
    // slot waiting for it. A beat leaving this cycle frees its slot now,
    // which is what keeps the stream bubble-free with only two entries.
    assign w_credit_used = {1'b0, w_fifo_count} + {2'b00, r_rd_inflight};
    assign w_credit_cap  = 3'd2 + {2'b00, w_beat};
    assign w_rd_en       = w_streaming && (r_rd_left != '0) && (w_credit_used < w_credit_cap);

    feeder_skid_fifo #(
        .WIDTH (ROW_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_inflight),
        .i_data  (mem_rd_data),
        .i_pop   (w_beat),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    // Tracks the one-cycle tile-buffer latency so returning data is pushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_inflight <= 1'b0;
        end else begin
            r_rd_inflight <= w_rd_en;
        end
    end

    // Job sequencer: phase control, read address/count and the pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_x_base          <= '0;
            r_num_vec         <= '0;
            r_rd_addr         <= '0;
            r_rd_left         <= '0;
            r_beat_left       <= '0;
            r_wait_cnt        <= '0;
            r_weight_latch_en <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so the later phase-entry loads
            // below take precedence over these per-cycle updates.
            r_weight_latch_en <= 1'b0;
            r_done            <= 1'b0;
            if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + ADDR_ONE;
                r_rd_left <= r_rd_left - CNT_ONE;
            end
            if (w_beat) begin
                r_beat_left <= r_beat_left - CNT_ONE;
            end

            unique case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_x_base  <= cmd_x_base;
                        r_num_vec <= cmd_num_vec;
                        if (!cmd_skip_weights) begin
                            r_state     <= W_LOAD;
                            r_rd_addr   <= cmd_w_base;
                            r_rd_left   <= N_WORDS;
                            r_beat_left <= N_WORDS;
                        end else if (cmd_num_vec == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= X_STREAM;
                            r_rd_addr   <= cmd_x_base;
                            r_rd_left   <= cmd_num_vec;
                            r_beat_left <= cmd_num_vec;
                        end
                    end
                end
                W_LOAD: begin
                    if (w_beat && (r_beat_left == CNT_ONE)) begin
                        r_state    <= W_WAIT;
                        r_wait_cnt <= W_WAIT_LAST;
                    end
                end
                W_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state           <= LATCH;
                        r_weight_latch_en <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_ONE;
                    end
                end
                LATCH: begin
                    if (r_num_vec == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= X_STREAM;
                        r_rd_addr   <= r_x_base;
                        r_rd_left   <= r_num_vec;
                        r_beat_left <= r_num_vec;
                    end
                end
                X_STREAM: begin
                    if (w_beat && (r_beat_left == CNT_ONE)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready       = (r_state == IDLE);
    assign busy            = (r_state != IDLE);
    assign mem_rd_en       = w_rd_en;
    assign mem_rd_addr     = r_rd_addr;
    assign valid_in        = w_fifo_valid;
    assign x_in            = w_fifo_valid ? w_fifo_data : '0;
    assign load_weight_in  = (w_fifo_valid && (r_state == W_LOAD)) ? {N{1'b1}} : '0;
    assign y_in            = '0;
    assign weight_latch_en = r_weight_latch_en;
    assign done            = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: random tile-buffer contents,
// scoreboard of expected reads and beats built from the job description,
// and a monitor that compares whatever the DUT presents.
module tb_systolic_feeder;

    localparam int N    = 8;
    localparam int DW   = 8;
    localparam int ACCW = 32;
    localparam int AW   = 12;
    localparam int CW   = 16;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_w_base;
    logic [AW-1:0]     cmd_x_base;
    logic [CW-1:0]     cmd_num_vec;
    logic              cmd_skip_weights;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_rd_addr;
    logic [N*DW-1:0]   mem_rd_data;
    logic [N-1:0]      load_weight_in;
    logic              valid_in;
    logic              ready_out;
    logic [N*DW-1:0]   x_in;
    logic [N*ACCW-1:0] y_in;
    logic              weight_latch_en;
    logic              busy;
    logic              done;

    systolic_feeder #(
        .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_w_base       (cmd_w_base),
        .cmd_x_base       (cmd_x_base),
        .cmd_num_vec      (cmd_num_vec),
        .cmd_skip_weights (cmd_skip_weights),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .load_weight_in   (load_weight_in),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .x_in             (x_in),
        .y_in             (y_in),
        .weight_latch_en  (weight_latch_en),
        .busy             (busy),
        .done             (done)
    );

    typedef struct {
        logic [N-1:0]    tag;
        logic [N*DW-1:0] data;
        bit              is_w;
    } beat_t;

    beat_t         exp_beats[$];
    logic [AW-1:0] exp_addrs[$];
    logic [N*DW-1:0] mem [1 << AW];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_mode = 0;
    int rdy_idx    = 0;

    int acc_cyc, last_w_cyc, latch_cyc, last_beat_cyc, prev_beat_cyc;
    int j_w_beats, j_x_beats, j_latch, j_done;
    bit prev_stall;
    logic [N*DW-1:0] prev_x;
    logic [N-1:0]    prev_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Tile buffer: data one cycle after the strobe, garbage otherwise.
    initial begin
        mem_rd_data = '0;
        forever begin
            @(posedge clk);
            if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
            else           mem_rd_data <= {$urandom, $urandom};
        end
    end

    // Core backpressure: always ready, 1,0,0,1 pattern, or random.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ready_out = 1'b1;
                1: begin
                    ready_out = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
                    rdy_idx++;
                end
                default: ready_out = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reads or transfers a beat.
    initial begin
        logic [AW-1:0] a;
        beat_t         b;
        acc_cyc = -1; last_w_cyc = -1; latch_cyc = -1; last_beat_cyc = -1; prev_beat_cyc = -1;
        j_w_beats = 0; j_x_beats = 0; j_latch = 0; j_done = 0;
        prev_stall = 1'b0; prev_x = '0; prev_tag = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc; last_w_cyc = -1; latch_cyc = -1; last_beat_cyc = -1;
                    j_w_beats = 0; j_x_beats = 0; j_latch = 0; j_done = 0;
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(valid_in), 64'd1);
                    check("stall_x", x_in, prev_x);
                    check("stall_tag", 64'(load_weight_in), 64'(prev_tag));
                end
                prev_stall = valid_in && !ready_out;
                prev_x     = x_in;
                prev_tag   = load_weight_in;

                if (mem_rd_en) begin
                    check("rd_expected", 64'(exp_addrs.size() > 0), 64'd1);
                    if (exp_addrs.size() > 0) begin
                        a = exp_addrs.pop_front();
                        check("rd_addr", 64'(mem_rd_addr), 64'(a));
                    end
                end

                if (valid_in && ready_out) begin
                    check("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
                    if (exp_beats.size() > 0) begin
                        b = exp_beats.pop_front();
                        check("beat_x", x_in, b.data);
                        check("beat_tag", 64'(load_weight_in), 64'(b.tag));
                        check("beat_y_zero", 64'(|y_in), 64'd0);
                        if (ready_mode == 0) begin
                            if (b.is_w) begin
                                if (j_w_beats == 0) check("first_w_latency", 64'(cyc - acc_cyc), 64'd3);
                                else                check("w_back_to_back", 64'(cyc - prev_beat_cyc), 64'd1);
                            end else begin
                                if (j_x_beats == 0)
                                    check("first_x_latency",
                                          64'((latch_cyc >= 0) ? (cyc - latch_cyc) : (cyc - acc_cyc)), 64'd3);
                                else
                                    check("x_back_to_back", 64'(cyc - prev_beat_cyc), 64'd1);
                            end
                        end
                        if (b.is_w) begin
                            j_w_beats++;
                            last_w_cyc = cyc;
                        end else begin
                            j_x_beats++;
                        end
                        prev_beat_cyc = cyc;
                        last_beat_cyc = cyc;
                    end
                end

                if (weight_latch_en) begin
                    j_latch++;
                    latch_cyc = cyc;
                    if (ready_mode == 0) check("latch_gap", 64'(cyc - last_w_cyc), 64'(2 * N + 1));
                end

                if (done) begin
                    j_done++;
                    check("done_beats_drained", 64'(exp_beats.size()), 64'd0);
                    if (ready_mode == 0)
                        check("done_timing",
                              64'(cyc - ((j_x_beats > 0) ? last_beat_cyc :
                                         (latch_cyc >= 0) ? latch_cyc : acc_cyc)), 64'd1);
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_valid_in"}, 64'(valid_in), 64'd0);
        check({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
        check({tag, "_latch_en"}, 64'(weight_latch_en), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_load_weight_in"}, 64'(load_weight_in), 64'd0);
        check({tag, "_x_in"}, x_in, 64'd0);
        check({tag, "_y_in"}, 64'(|y_in), 64'd0);
        check({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_beats.delete();
        exp_addrs.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic push_expected(input logic [AW-1:0] w_base, input logic [AW-1:0] x_base,
                                 input int nv, input bit skip);
        logic [AW-1:0] a;
        beat_t         b;
        if (!skip) begin
            for (int i = 0; i < N; i++) begin
                a = w_base + AW'(i);
                exp_addrs.push_back(a);
                b.tag = '1; b.data = mem[a]; b.is_w = 1'b1;
                exp_beats.push_back(b);
            end
        end
        for (int i = 0; i < nv; i++) begin
            a = x_base + AW'(i);
            exp_addrs.push_back(a);
            b.tag = '0; b.data = mem[a]; b.is_w = 1'b0;
            exp_beats.push_back(b);
        end
    endtask

    task automatic issue_cmd(input logic [AW-1:0] w_base, input logic [AW-1:0] x_base,
                             input int nv, input bit skip);
        bit accepted;
        @(posedge clk);
        #2;
        cmd_w_base = w_base; cmd_x_base = x_base;
        cmd_num_vec = CW'(nv); cmd_skip_weights = skip;
        cmd_valid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 100 && !accepted; k++) begin
            @(negedge clk);
            accepted = cmd_ready;
        end
        check("cmd_accepted", 64'(accepted), 64'd1);
        @(posedge clk);
        #2;
        // A weight phase lasts at least N cycles: keep offering junk commands,
        // which must be ignored while the job runs.
        if (!skip) begin
            for (int k = 0; k < 4; k++) begin
                cmd_w_base = AW'($urandom); cmd_x_base = AW'($urandom);
                cmd_num_vec = CW'($urandom_range(0, 20)); cmd_skip_weights = 1'($urandom_range(0, 1));
                @(posedge clk);
                #2;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input logic [AW-1:0] w_base, input logic [AW-1:0] x_base,
                           input int nv, input bit skip, input int mode);
        ready_mode = mode;
        rdy_idx    = 0;
        push_expected(w_base, x_base, nv, skip);
        issue_cmd(w_base, x_base, nv, skip);
        for (int k = 0; k < 3000 && j_done == 0; k++) @(negedge clk);
        check("job_done_seen", 64'(j_done), 64'd1);
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(j_done), 64'd1);
        check("latch_pulses", 64'(j_latch), skip ? 64'd0 : 64'd1);
        check("w_beats", 64'(j_w_beats), skip ? 64'd0 : 64'(N));
        check("x_beats", 64'(j_x_beats), 64'(nv));
        check("beats_left", 64'(exp_beats.size()), 64'd0);
        check("reads_left", 64'(exp_addrs.size()), 64'd0);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        if (j_done == 0) apply_reset();
    endtask

    initial begin
        int nv;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_w_base = '0; cmd_x_base = '0;
        cmd_num_vec = '0; cmd_skip_weights = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};

        #1;
        check_quiet("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("post_reset_busy", 64'(busy), 64'd0);

        // Full job, no backpressure, then with the 1,0,0,1 stall pattern.
        run_job(12'h010, 12'h100, 4, 1'b0, 0);
        run_job(12'h010, 12'h100, 4, 1'b0, 1);
        // Weight reuse.
        run_job(12'h000, 12'h2A0, 3, 1'b1, 0);
        // Address wrap in both phases.
        run_job(12'h000, 12'hFFE, 4, 1'b1, 0);
        run_job(12'hFFC, 12'hFFD, 5, 1'b0, 2);
        // Zero-length activation phases.
        run_job(12'h040, 12'h000, 0, 1'b0, 0);
        run_job(12'h000, 12'h000, 0, 1'b1, 0);

        // Random jobs.
        for (int j = 0; j < 6; j++) begin
            run_job(AW'($urandom), AW'($urandom), $urandom_range(0, 12),
                    1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Reset in the middle of an activation stream.
        ready_mode = 0;
        push_expected(12'h000, 12'h200, 10, 1'b1);
        issue_cmd(12'h000, 12'h200, 10, 1'b1);
        for (int k = 0; k < 200 && j_x_beats < 2; k++) @(negedge clk);
        check("mid_job_two_beats", 64'(j_x_beats >= 2), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        exp_beats.delete();
        exp_addrs.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("mid_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("post_reset_quiet", 64'({valid_in, mem_rd_en, busy, done, weight_latch_en}), 64'd0);
        end

        // Recovery after the abandoned job.
        nv = $urandom_range(1, 8);
        run_job(12'h300, 12'h400, nv, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a hung simulation.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "global timeout");
    end

endmodule
